// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state enum for the wait-state sequencer
//   - MEM/WB pipeline register layout
//   - lane_mask(): byte-write-enable pattern for a store of a given size
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // MEM/WB register contents; an all-zero value is a bubble.
    typedef struct packed {
        logic        valid;
        logic        regdst;
        logic        wb_data;
        logic        reg_write;
        logic        misalign;
        logic [31:0] alu_out;
        logic [31:0] read_data;
        logic [31:0] instr;
    } memwb_t;

    // Little-endian lane enables. Halves use addr[1] only and words ignore
    // the low bits, so unaligned requests are naturally aligned down.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem
// Word-organised data memory with per-byte write enables and asynchronous read.
// Ports:
//   clk    in  write clock
//   addr   in  word index
//   we     in  4-bit byte-lane write enable (bit i writes wdata[8i+7:8i])
//   wdata  in  32-bit write data (already replicated into the active lanes)
//   rdata  out 32-bit combinational read of the addressed word
// -----------------------------------------------------------------------------
module mem_stage_dmem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; memory contents must
    // survive rst_n, and a reset loop would also prevent RAM inference.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// -----------------------------------------------------------------------------
// mem_stage_pipe
// Registered MEM stage: byte/half/word loads and stores against an internal
// data memory with WAIT_CYCLES extra cycles per access, plus the MEM/WB
// pipeline register.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN -- when defined,
// misaligned half/word accesses are trapped (no write, no stall, read_data 0,
// reg_write 0, misalign_out 1); when undefined they are aligned down and
// misalign_out stays 0.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid                        EX/MEM slot holds a real instruction
//   alu_out_in, store_data_in       effective address / store data
//   instr_in                        instruction word, forwarded
//   mem_read_in, mem_write_in       load / store request
//   mem_size_in, mem_unsigned_in    access size, zero-extend loads
//   regdst_in, wb_data_in,
//   reg_write_in                    WB controls, forwarded
//   stall_out                       combinational stall to earlier stages
//   out_valid, regdst, wb_data,
//   reg_write, alu_out, read_data,
//   instr, misalign_out             registered MEM/WB outputs
// -----------------------------------------------------------------------------
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_out_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [31:0]       instr_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic              regdst_in,
    input  logic              wb_data_in,
    input  logic              reg_write_in,
    output logic              stall_out,
    output logic              out_valid,
    output logic              regdst,
    output logic              wb_data,
    output logic              reg_write,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] read_data,
    output logic [31:0]       instr,
    output logic              misalign_out
);

    localparam int         AW       = $clog2(MEM_DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        mem_op, trap, start, commit, stall_int;
    logic [3:0]  we;
    logic [31:0] wdata, rdata, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    memwb_t      memwb_q, memwb_d;

    assign mem_op = mem_read_in | mem_write_in;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap = in_valid && mem_op &&
                  (((mem_size_in == SZ_HALF) && alu_out_in[0]) ||
                   ((mem_size_in[1] == 1'b1) && (alu_out_in[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    assign start = in_valid && mem_op && (WAIT_CYCLES > 0) && !trap;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value held, which would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_int  = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall_int  = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end else begin
                    commit = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    stall_int = 1'b1;
                    cnt_next  = cnt - 4'd1;
                end else begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gating with rst_n drops the stall and blocks any write the instant
    // reset asserts, even while the upstream still presents the access.
    assign stall_out = rst_n & stall_int;
    assign we = (rst_n && commit && in_valid && mem_write_in && !trap)
              ? lane_mask(mem_size_in, alu_out_in[1:0]) : 4'b0000;

    always_comb begin
        case (mem_size_in)
            SZ_BYTE: wdata = {4{store_data_in[7:0]}};
            SZ_HALF: wdata = {2{store_data_in[15:0]}};
            default: wdata = store_data_in[31:0];
        endcase
    end

    mem_stage_dmem #(
        .DEPTH (MEM_DEPTH)
    ) u_dmem (
        .clk   (clk),
        .addr  (alu_out_in[AW+1:2]),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        case (alu_out_in[1:0])
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = alu_out_in[1] ? rdata[31:16] : rdata[15:0];
        case (mem_size_in)
            SZ_BYTE: ld_val = mem_unsigned_in ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = mem_unsigned_in ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = rdata;
        endcase
    end

    always_comb begin
        memwb_d = '0;
        if (in_valid) begin
            memwb_d.valid     = 1'b1;
            memwb_d.regdst    = regdst_in;
            memwb_d.wb_data   = wb_data_in;
            memwb_d.reg_write = reg_write_in && !trap;
            memwb_d.misalign  = trap;
            memwb_d.alu_out   = alu_out_in[31:0];
            memwb_d.instr     = instr_in;
            memwb_d.read_data = (mem_read_in && !mem_write_in && !trap) ? ld_val : 32'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            memwb_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            // While an access is still waiting, WB sees a bubble.
            memwb_q <= commit ? memwb_d : '0;
        end
    end

    assign out_valid    = memwb_q.valid;
    assign regdst       = memwb_q.regdst;
    assign wb_data      = memwb_q.wb_data;
    assign reg_write    = memwb_q.reg_write;
    assign misalign_out = memwb_q.misalign;
    assign alu_out      = memwb_q.alu_out;
    assign read_data    = memwb_q.read_data;
    assign instr        = memwb_q.instr;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_pipe
// Directed bench with two instances sharing input buses: u0 (WAIT_CYCLES=0)
// and u3 (WAIT_CYCLES=3). Each instance has its own in_valid so only the
// instance under test sees real instructions; the other sees bubbles.
// -----------------------------------------------------------------------------
module tb_mem_stage_pipe;
    import mem_stage_pkg::*;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v3;
    logic [31:0] alu_in, sd_in, instr_in;
    logic        mr, mw, mu, regdst_in, wbd_in, rw_in;
    logic [1:0]  msz;

    logic        stall0, ov0, regdst0, wbd0, rw0, mis0;
    logic [31:0] alu0, rdata0, instr0;
    logic        stall3, ov3, regdst3, wbd3, rw3, mis3;
    logic [31:0] alu3, rdata3, instr3;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic stall_seen0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(32), .MEM_DEPTH(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .alu_out_in(alu_in),
        .store_data_in(sd_in), .instr_in(instr_in), .mem_read_in(mr),
        .mem_write_in(mw), .mem_size_in(msz), .mem_unsigned_in(mu),
        .regdst_in(regdst_in), .wb_data_in(wbd_in), .reg_write_in(rw_in),
        .stall_out(stall0), .out_valid(ov0), .regdst(regdst0), .wb_data(wbd0),
        .reg_write(rw0), .alu_out(alu0), .read_data(rdata0), .instr(instr0),
        .misalign_out(mis0));

    mem_stage_pipe #(.DATA_W(32), .MEM_DEPTH(1024), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .alu_out_in(alu_in),
        .store_data_in(sd_in), .instr_in(instr_in), .mem_read_in(mr),
        .mem_write_in(mw), .mem_size_in(msz), .mem_unsigned_in(mu),
        .regdst_in(regdst_in), .wb_data_in(wbd_in), .reg_write_in(rw_in),
        .stall_out(stall3), .out_valid(ov3), .regdst(regdst3), .wb_data(wbd3),
        .reg_write(rw3), .alu_out(alu3), .read_data(rdata3), .instr(instr3),
        .misalign_out(mis3));

    // Stimulus only: regdst/wb_data follow reg_write/read for easy checking.
    task automatic drive(input logic v_0, input logic v_3, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic rw);
        v0 = v_0; v3 = v_3; mr = rd; mw = wr; msz = sz; mu = uns;
        alu_in = addr; sd_in = sd; rw_in = rw; regdst_in = rw; wbd_in = rd;
        instr_in = {8'hA5, addr[23:0]};
    endtask

    // One access on u0: present, note stall, cross one edge.
    task automatic access0(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] sd, input logic rw);
        drive(1'b1, 1'b0, rd, wr, sz, uns, addr, sd, rw);
        #1 stall_seen0 = stall_seen0 | stall0;
        @(posedge clk); #1;
    endtask

    // One access on u3 (already driven): count stall cycles, then the commit edge.
    task automatic run3(output int stalls, output bit timeout);
        stalls = 0; timeout = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (stall3 !== 1'b1) begin timeout = 1'b0; break; end
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({ov0, regdst0, wbd0, rw0, mis0, alu0, rdata0, instr0, stall0} !== '0) begin
            n_fail++; $display("FAIL reset_u0: got %h expected 0", {ov0, regdst0, wbd0, rw0, mis0, alu0, rdata0, instr0, stall0});
        end
        n_checks++;
        if ({ov3, regdst3, wbd3, rw3, mis3, alu3, rdata3, instr3, stall3} !== '0) begin
            n_fail++; $display("FAIL reset_u3: got %h expected 0", {ov3, regdst3, wbd3, rw3, mis3, alu3, rdata3, instr3, stall3});
        end
    endtask

    task automatic test_word_rw();
        stall_seen0 = 1'b0;
        access0(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        n_checks++;
        if ({ov0, rw0, alu0, rdata0} !== {1'b1, 1'b0, 32'h10, 32'h0}) begin
            n_fail++; $display("FAIL sw_slot: got %h expected %h", {ov0, rw0, alu0, rdata0}, {1'b1, 1'b0, 32'h10, 32'h0});
        end
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);
        n_checks++;
        if (rdata0 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL lw_word: got %h expected %h", rdata0, 32'hDEADBEEF);
        end
        n_checks++;
        if ({ov0, rw0, regdst0, wbd0, instr0} !== {4'b1111, 32'hA5000010}) begin
            n_fail++; $display("FAIL lw_ctrl: got %h expected %h", {ov0, rw0, regdst0, wbd0, instr0}, {4'b1111, 32'hA5000010});
        end
        n_checks++;
        if (stall_seen0 !== 1'b0) begin
            n_fail++; $display("FAIL wait0_stall: got %b expected 0", stall_seen0);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] exp_tab [6];
        exp_tab = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AD, 32'h000080AD, 32'hFFFFFFEF, 32'hFFFFBEEF};
        // Word 0x10 becomes 0x80ADBEEF after sb 0x80 to 0x13.
        access0(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345680, 1'b0);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: access0(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b1);
                1: access0(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b1);
                2: access0(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b1);
                3: access0(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 1'b1);
                4: access0(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 1'b1);
                default: access0(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 1'b1);
            endcase
            n_checks++;
            if (rdata0 !== exp_tab[i]) begin
                n_fail++; $display("FAIL load_ext[%0d]: got %h expected %h", i, rdata0, exp_tab[i]);
            end
        end
        // sh 0x1234 to 0x10 touches lanes 0-1 only.
        access0(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h10, 32'h99991234, 1'b0);
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);
        n_checks++;
        if (rdata0 !== 32'h80AD1234) begin
            n_fail++; $display("FAIL sh_lanes: got %h expected %h", rdata0, 32'h80AD1234);
        end
    endtask

    task automatic test_rw_both();
        access0(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h12345678, 1'b1);
        n_checks++;
        if ({ov0, rdata0} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rw_both_rdata: got %h expected %h", {ov0, rdata0}, {1'b1, 32'h0});
        end
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b1);
        n_checks++;
        if (rdata0 !== 32'h12345678) begin
            n_fail++; $display("FAIL rw_both_write: got %h expected %h", rdata0, 32'h12345678);
        end
    endtask

    task automatic test_wrap();
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h1010, 32'h0, 1'b1);
        n_checks++;
        if (rdata0 !== 32'h80AD1234) begin
            n_fail++; $display("FAIL wrap_low: got %h expected %h", rdata0, 32'h80AD1234);
        end
        access0(1'b0, 1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b0);
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h2FFC, 32'h0, 1'b1);
        n_checks++;
        if (rdata0 !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL wrap_top: got %h expected %h", rdata0, 32'hCAFEF00D);
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if ({ov0, regdst0, wbd0, rw0, mis0, alu0, rdata0, instr0} !== '0) begin
            n_fail++; $display("FAIL bubble: got %h expected 0", {ov0, regdst0, wbd0, rw0, mis0, alu0, rdata0, instr0});
        end
    endtask

    task automatic test_alu_op();
        access0(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h00000ABC, 32'h0, 1'b1);
        n_checks++;
        if ({ov0, rw0, regdst0, alu0, rdata0, instr0} !== {3'b111, 32'hABC, 32'h0, 32'hA5000ABC}) begin
            n_fail++; $display("FAIL alu_op: got %h expected %h", {ov0, rw0, regdst0, alu0, rdata0, instr0}, {3'b111, 32'hABC, 32'h0, 32'hA5000ABC});
        end
    endtask

    task automatic test_misalign();
        stall_seen0 = 1'b0;
        access0(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 1'b0);
        access0(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0000CAFE, 1'b0);
        n_checks++;
        if ({ov0, mis0, stall_seen0} !== {1'b1, TRAP, 1'b0}) begin
            n_fail++; $display("FAIL sh_misalign_flag: got %b expected %b", {ov0, mis0, stall_seen0}, {1'b1, TRAP, 1'b0});
        end
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b1);
        n_checks++;
        if (rdata0 !== (TRAP ? 32'h11223344 : 32'h1122CAFE)) begin
            n_fail++; $display("FAIL sh_misalign_mem: got %h expected %h", rdata0, TRAP ? 32'h11223344 : 32'h1122CAFE);
        end
        access0(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0, 1'b1);
        n_checks++;
        if ({mis0, rw0, rdata0} !== (TRAP ? {2'b10, 32'h0} : {2'b01, 32'h1122CAFE})) begin
            n_fail++; $display("FAIL lw_misalign: got %h expected %h", {mis0, rw0, rdata0}, TRAP ? {2'b10, 32'h0} : {2'b01, 32'h1122CAFE});
        end
        access0(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 1'b1);
        n_checks++;
        if ({mis0, rdata0} !== {1'b0, (TRAP ? 32'h00000033 : 32'hFFFFFFCA)}) begin
            n_fail++; $display("FAIL lb_odd: got %h expected %h", {mis0, rdata0}, {1'b0, (TRAP ? 32'h00000033 : 32'hFFFFFFCA)});
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        bit to;
        drive(1'b0, 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h55667788, 1'b0);
        run3(stalls, to);
        n_checks++;
        if ({to, stalls, ov3} !== {1'b0, 32'd3, 1'b1}) begin
            n_fail++; $display("FAIL w3_sw: got timeout=%b stalls=%0d valid=%b expected 0/3/1", to, stalls, ov3);
        end
        // Presented right after the store's commit edge: must stall at once.
        drive(1'b0, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b1);
        run3(stalls, to);
        n_checks++;
        if ({to, stalls, ov3, rdata3} !== {1'b0, 32'd3, 1'b1, 32'h55667788}) begin
            n_fail++; $display("FAIL w3_lw: got timeout=%b stalls=%0d valid=%b data=%h expected 0/3/1/55667788", to, stalls, ov3, rdata3);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h777, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (stall3 !== 1'b0) begin
            n_fail++; $display("FAIL w3_alu_stall: got %b expected 0", stall3);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ov3, rw3, alu3, rdata3} !== {2'b11, 32'h777, 32'h0}) begin
            n_fail++; $display("FAIL w3_alu: got %h expected %h", {ov3, rw3, alu3, rdata3}, {2'b11, 32'h777, 32'h0});
        end
    endtask

    task automatic test_reset_busy();
        int stalls;
        bit to;
        drive(1'b0, 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11111111, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (stall3 !== 1'b1) begin
            n_fail++; $display("FAIL busy_stall: got %b expected 1", stall3);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stall3, ov3, rw3, alu3, rdata3, instr3} !== '0) begin
            n_fail++; $display("FAIL busy_reset: got %h expected 0", {stall3, ov3, rw3, alu3, rdata3, instr3});
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b1);
        run3(stalls, to);
        n_checks++;
        if ({to, rdata3} !== {1'b0, 32'h55667788}) begin
            n_fail++; $display("FAIL busy_abandon: got timeout=%b data=%h expected 0/55667788", to, rdata3);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall_seen0 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_word_rw();
        test_byte_half();
        test_rw_both();
        test_wrap();
        test_bubble();
        test_alu_op();
        test_misalign();
        test_back_to_back();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised, registered MEM stage for the MIPS pipeline: sits between EX/MEM and WB, performs byte/half/word loads and stores against an internal word-organised data memory with configurable wait states, and owns the MEM/WB pipeline register. Unlike the earlier combinational pass-through stage, it applies byte-lane stores and sign/zero-extended loads, and asserts a stall back to the earlier stages while a multi-cycle access is in flight.

## Interface
- DATA_W, 32: datapath width. Only 32 is supported.
- MEM_DEPTH, 1024: data memory depth in words; power of two.
- WAIT_CYCLES, 0: extra stall cycles per load/store, 0..15.
- clk  in  1  rising-edge clock (one clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a real instruction.
- alu_out_in  in  DATA_W  ALU result / effective byte address.
- store_data_in  in  DATA_W  rt value for stores.
- instr_in  in  32  instruction word, forwarded.
- mem_read_in, mem_write_in  in  1 each  load / store request.
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned_in  in  1  zero-extend loads (lbu/lhu).
- regdst_in, wb_data_in, reg_write_in  in  1 each  WB controls, forwarded.
- stall_out  out  1  combinational; upstream must hold all inputs stable while high.
- out_valid, regdst, wb_data, reg_write  out  1 each  registered MEM/WB controls.
- alu_out, read_data, instr  out  DATA_W/DATA_W/32  registered MEM/WB data.
- misalign_out  out  1  registered misaligned-access flag.

## Operation
- FSM states: IDLE, BUSY. Counter cnt, 4 bits.
- IDLE, in_valid, memory op (read or write), WAIT_CYCLES>0, not trapped: stall_out=1, go BUSY, cnt=WAIT_CYCLES-1.
- BUSY, cnt>0: stall_out=1, cnt decrements.
- BUSY, cnt==0: stall_out=0; at the edge, commit the access, load the MEM/WB register, return to IDLE.
- WAIT_CYCLES=0, or non-memory op: no stall; the access commits at the edge of presentation.
- Word index = alu_out_in[log2(MEM_DEPTH)+1:2]; higher address bits ignored (wrap modulo depth).
- Store: sb writes the lane selected by addr[1:0] with store_data_in[7:0]; sh writes lanes addr[1]*2+{0,1} with [15:0]; sw writes all four lanes. Little-endian lanes.
- Load: select byte/half by addr low bits; sign-extend unless mem_unsigned_in. read_data=0 for non-loads.
- read and write both set: write performed, read_data=0.
- in_valid=0: bubble; next edge out_valid=0, reg_write=0, other outputs 0.
- Memory contents are not affected by reset.

## Timing
- Reset (async assert): state IDLE, cnt 0; out_valid, regdst, wb_data, reg_write, misalign_out 0; alu_out, read_data, instr 0. stall_out 0.
- Non-memory op: MEM/WB outputs valid 1 edge after presentation.
- Memory op: stall_out high exactly WAIT_CYCLES cycles; outputs valid WAIT_CYCLES+1 edges after first presentation.
- Reset during BUSY: access abandoned, no write committed, stall_out drops immediately.
- Back-to-back memory ops: second enters the wait sequence the cycle after the first completes; no dead cycle.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined: half with addr[0]=1, or word with addr[1:0]!=0, is trapped: no stall, no write, read_data=0, reg_write=0, misalign_out=1 with out_valid=1 for one cycle.
- Undefined: misalign_out tied 0; low address bits below the access size are ignored (access aligned down).

## Structure
- Package mem_stage_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, lane-mask function.
- One sub-module: mem_stage_dmem — word array with 4-bit byte-write-enable and asynchronous read.

## Test plan
- Reset, WAIT_CYCLES=0: sw 0xDEADBEEF to 0x10, lw 0x10 -> read_data=0xDEADBEEF next edge, stall_out never high.
- sb 0x80 to 0x13, lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF80AD.
- WAIT_CYCLES=3, lw -> stall_out high 3 cycles, out_valid on 4th edge; following ALU op completes 1 edge later.
- Bubble (in_valid=0, reg_write_in=1) -> out_valid=0, reg_write=0.
- rst_n low during BUSY of sw 0x11111111 to 0x20 -> outputs 0, later lw 0x20 returns prior contents.
- With MEM_STAGE_MISALIGN_TRAP_EN, sh to 0x21 -> misalign_out=1, memory unchanged, no stall; without it, writes lanes 0-1 of word 0x20.
